imageproc_cmd_ctrl: RTL and testbench
=====================================

# imageproc_cmd_ctrl

- Host-side command responder for the image processor's `cmd`/`cmd_data`/`cmd_valid`/`cmd_ack` interface. Drives `busy`, `refresh` and `error`.
- Decodes and range-checks each command. Latches the operation select (`op_sel`) and argument (`op_arg`) for the pixel pipeline, and pulses `start` to launch a frame pass.
- Stays busy until the write-back path has delivered exactly one frame of pixel writes.
- Sits between the host and the read/process/write pipeline.

## Interface
Parameters:
- `FRAME_PIXELS`, 102400: write strobes per frame (320×320).
- `TIMEOUT_CYCLES`, 1024: watchdog limit, in cycles without a write strobe. Used only when `IMGPROC_CMD_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd` in 4: command code.
- `cmd_data` in 8: command argument.
- `cmd_valid` in 1: host request level, held until acked.
- `cmd_ack` out 1: one-cycle acknowledge pulse.
- `busy` out 1: frame pass in progress.
- `refresh` out 1: one-cycle pulse when the frame write-back completes.
- `error` out 1: sticky error flag.
- `op_sel` out 2: 0 ROTATE, 1 ZOOM, 2 BLACKWHITE, 3 INVERSION.
- `op_arg` out 8: latched argument (rotate angle / zoom factor).
- `start` out 1: one-cycle pulse that launches the read engine.
- `wr_valid` in 1: write-back strobe, one pulse per pixel written.

## Operation
- **Reset values:** `cmd_ack`=0, `busy`=0, `refresh`=0, `error`=0, `op_sel`=0, `op_arg`=0, `start`=0. State IDLE, `armed`=1, pixel counter=0, watchdog=0.
- **States:**
  - IDLE: waiting for a command.
  - RUN: frame pass in progress.
- **Re-arm rule:** the internal `armed` flag clears on every ack. It sets again when `cmd_valid` is sampled low. A command is accepted only when the state is IDLE, `armed`=1 and `cmd_valid`=1.
- **Command decode on acceptance** (every accepted command is acked):
  - `cmd`=0 ROTATE: valid if `cmd_data`≤90.
  - `cmd`=1 ZOOM: valid if `cmd_data`≠0.
  - `cmd`=2 BLACKWHITE, `cmd`=3 INVERSION: `cmd_data` is ignored.
  - Valid op: latch `op_sel`=`cmd[1:0]` and `op_arg`=`cmd_data`; pulse `start`; go to RUN; `busy`=1.
  - `cmd`=4 CLEAR_ERROR: `error`=0. No state change, no `start`.
  - Invalid argument, or `cmd`≥5: `error`=1. `op_sel` and `op_arg` keep their values, no `start`, stay IDLE.
- **While busy:** `cmd_valid` is not acked. The host must keep holding it; it is accepted after return to IDLE, provided `armed`=1.
- **RUN:**
  - The 17-bit pixel counter increments on each `wr_valid`.
  - When the counter reaches `FRAME_PIXELS`: clear the counter, pulse `refresh`, set `busy`=0, return to IDLE.
  - `wr_valid` received in IDLE is ignored and does not affect the counter.
- **Reset mid-RUN:** all outputs return to their reset values immediately (asynchronous). No `refresh` is emitted.

## Timing
- **Accept:** `cmd_valid` sampled high at edge N. At edge N, `cmd_ack`, `start`, `busy`, `op_sel`, `op_arg` and `error` all register. They are visible during cycle N+1.
- **Pulse widths:** `cmd_ack` and `start` are high for exactly one cycle.
- **Re-arm:** the earliest next acceptance is at the first edge after `cmd_valid` has been sampled low.
- **Completion:** final `wr_valid` sampled at edge M. `refresh`=1 and `busy`=0 during cycle M+1. A new command can be accepted at edge M+1 if `armed`=1.
- **Same-edge events:** when `cmd_valid` and the final `wr_valid` are sampled at the same edge, the command is not accepted at that edge; it is accepted at the next edge.
- **Output registration:** all outputs come directly from registers; none are combinational from inputs.

## Configuration
- **Macro:** `IMGPROC_CMD_TIMEOUT_EN`.
- **Defined:** a watchdog counts cycles in RUN and clears on each `wr_valid`. When it reaches `TIMEOUT_CYCLES`, the block sets `error`=1, `busy`=0 and the pixel counter to 0, returns to IDLE, and emits no `refresh`.
- **Undefined:** no watchdog logic is built. RUN waits indefinitely.

## Test plan
- **Reset:** hold `rst_n`=0, then release → all outputs 0. `cmd_valid`=1 with `cmd`=2 → `cmd_ack`, `start` and `busy` rise one cycle later; `op_sel`=2.
- **ROTATE, full frame:** `cmd`=0, `cmd_data`=10; drive 102400 `wr_valid` pulses → `refresh` is a single pulse the cycle after the last strobe, `busy` falls with it, `op_arg`=10.
- **Bad arguments:** `cmd`=0 with `cmd_data`=91 → ack, `error`=1, no `start`, `busy`=0. Then `cmd`=4 → ack, `error`=0. `cmd`=1 with `cmd_data`=0 → `error`=1.
- **Held request:** `cmd_valid` held high through a whole frame → exactly one ack. Drop `cmd_valid` for 1 cycle, then raise with `cmd`=3 → second ack and `start`; `op_sel`=3.
- **Reset mid-frame:** 50000 strobes, then pulse `rst_n` → `busy`=0 immediately and no `refresh`. The next command needs the full 102400 strobes before `refresh`.
- **Watchdog** (`IMGPROC_CMD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): start a command, send 10 strobes, then stall → `error`=1 and `busy`=0 after 16 idle cycles, no `refresh`.

Source files
------------

// File: rtl/imageproc_cmd_ctrl_if.sv
// Host command bus for imageproc_cmd_ctrl: request/argument/valid from the host,
// acknowledge and status flags back to it.
interface imageproc_cmd_ctrl_if;
  logic [3:0] cmd;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ack;
  logic       busy;
  logic       refresh;
  logic       error;

  modport master (
    output cmd, cmd_data, cmd_valid,
    input  cmd_ack, busy, refresh, error
  );

  modport slave (
    input  cmd, cmd_data, cmd_valid,
    output cmd_ack, busy, refresh, error
  );
endinterface

// File: rtl/imageproc_cmd_ctrl.sv
// Host command responder: decodes/range-checks commands, launches one frame pass and waits
// for a full frame of write strobes. Optional watchdog enabled by IMGPROC_CMD_TIMEOUT_EN.
module imageproc_cmd_ctrl #(
  parameter int unsigned FRAME_PIXELS   = 102400,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  imageproc_cmd_ctrl_if.slave        host,
  output logic [1:0]                 op_sel,
  output logic [7:0]                 op_arg,
  output logic                       start,
  input  logic                       wr_valid
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [16:0] LastPix = 17'(FRAME_PIXELS - 1);

  state_e      state_q;
  logic        armed_q;
  logic [16:0] pix_cnt_q;
  logic        cmd_ack_q;
  logic        busy_q;
  logic        refresh_q;
  logic        error_q;
  logic [1:0]  op_sel_q;
  logic [7:0]  op_arg_q;
  logic        start_q;

  logic cmd_op_ok;
  logic cmd_clr;
  logic accept;
  logic wd_expire;

  always_comb begin
    cmd_op_ok = 1'b0;
    cmd_clr   = 1'b0;
    case (host.cmd)
      4'd0:       cmd_op_ok = (host.cmd_data <= 8'd90);
      4'd1:       cmd_op_ok = (host.cmd_data != 8'd0);
      4'd2, 4'd3: cmd_op_ok = 1'b1;
      4'd4:       cmd_clr   = 1'b1;
      default:    ;
    endcase
  end

  assign accept = (state_q == StIdle) && armed_q && host.cmd_valid;

`ifdef IMGPROC_CMD_TIMEOUT_EN
  localparam int unsigned    WdW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q;

  // Counts RUN cycles since the last strobe; fires on the cycle that would reach the limit.
  assign wd_expire = (state_q == StRun) && !wr_valid && (wd_q == WdLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (state_q != StRun || wr_valid || wd_expire) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expire          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      armed_q   <= 1'b1;
      pix_cnt_q <= '0;
      cmd_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      refresh_q <= 1'b0;
      error_q   <= 1'b0;
      op_sel_q  <= '0;
      op_arg_q  <= '0;
      start_q   <= 1'b0;
    end else begin
      cmd_ack_q <= 1'b0;
      start_q   <= 1'b0;
      refresh_q <= 1'b0;
      // A held request must be dropped once before it can be accepted again.
      if (!host.cmd_valid) armed_q <= 1'b1;

      case (state_q)
        StIdle: begin
          if (accept) begin
            cmd_ack_q <= 1'b1;
            armed_q   <= 1'b0;
            if (cmd_op_ok) begin
              op_sel_q <= host.cmd[1:0];
              op_arg_q <= host.cmd_data;
              start_q  <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= StRun;
            end else if (cmd_clr) begin
              error_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (wd_expire) begin
            error_q   <= 1'b1;
            busy_q    <= 1'b0;
            pix_cnt_q <= '0;
            state_q   <= StIdle;
          end else if (wr_valid) begin
            if (pix_cnt_q == LastPix) begin
              pix_cnt_q <= '0;
              refresh_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end else begin
              pix_cnt_q <= pix_cnt_q + 17'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign host.cmd_ack = cmd_ack_q;
  assign host.busy    = busy_q;
  assign host.refresh = refresh_q;
  assign host.error   = error_q;
  assign op_sel       = op_sel_q;
  assign op_arg       = op_arg_q;
  assign start        = start_q;

endmodule

// File: tb/tb_imageproc_cmd_ctrl.sv
// Directed bench for imageproc_cmd_ctrl with a shortened frame; watchdog section is
// built only when IMGPROC_CMD_TIMEOUT_EN is defined.
module tb_imageproc_cmd_ctrl;

  localparam int unsigned Fp = 300;
  localparam int unsigned To = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] op_sel;
  logic [7:0] op_arg;
  logic       start;
  logic       wr_valid;

  int n_checks;
  int n_errors;
  int ack_seen;
  int refresh_seen;

  imageproc_cmd_ctrl_if host_if ();

  imageproc_cmd_ctrl #(
    .FRAME_PIXELS  (Fp),
    .TIMEOUT_CYCLES(To)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (host_if),
    .op_sel  (op_sel),
    .op_arg  (op_arg),
    .start   (start),
    .wr_valid(wr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      tick();
      if (host_if.cmd_ack) ack_seen++;
      if (host_if.refresh) refresh_seen++;
    end
    wr_valid = 1'b0;
  endtask

  // Issue one command and check the acknowledge cycle; request is dropped afterwards.
  task automatic issue(input string tag, input logic [3:0] c, input logic [7:0] d,
                       input logic exp_start);
    host_if.cmd       = c;
    host_if.cmd_data  = d;
    host_if.cmd_valid = 1'b1;
    tick();
    check({tag, "_ack"}, 32'(host_if.cmd_ack), 32'd1);
    check({tag, "_start"}, 32'(start), 32'(exp_start));
    check({tag, "_busy"}, 32'(host_if.busy), 32'(exp_start));
    host_if.cmd_valid = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, 32'(host_if.cmd_ack), 32'd0);
    check({tag, "_start_pulse"}, 32'(start), 32'd0);
  endtask

  task automatic frame_done(input string tag);
    refresh_seen = 0;
    strobes(Fp - 1);
    check({tag, "_busy_pre"}, 32'(host_if.busy), 32'd1);
    check({tag, "_no_early_refresh"}, 32'(refresh_seen), 32'd0);
    strobes(1);
    check({tag, "_refresh"}, 32'(host_if.refresh), 32'd1);
    check({tag, "_busy_done"}, 32'(host_if.busy), 32'd0);
    tick();
    check({tag, "_refresh_pulse"}, 32'(host_if.refresh), 32'd0);
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    ack_seen          = 0;
    refresh_seen      = 0;
    rst_n             = 1'b0;
    wr_valid          = 1'b0;
    host_if.cmd       = 4'd0;
    host_if.cmd_data  = 8'd0;
    host_if.cmd_valid = 1'b0;

    // Reset
    repeat (3) tick();
    check("rst_busy", 32'(host_if.busy), 32'd0);
    check("rst_ack", 32'(host_if.cmd_ack), 32'd0);
    check("rst_error", 32'(host_if.error), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_busy", 32'(host_if.busy), 32'd0);
    check("rel_start", 32'(start), 32'd0);
    check("rel_op", {22'd0, op_sel, op_arg}, 32'd0);

    // BLACKWHITE right after reset
    issue("bw", 4'd2, 8'h55, 1'b1);
    check("bw_op_sel", 32'(op_sel), 32'd2);
    check("bw_op_arg", 32'(op_arg), 32'h55);
    frame_done("bw");

    // ROTATE full frame
    issue("rot", 4'd0, 8'd10, 1'b1);
    check("rot_op_sel", 32'(op_sel), 32'd0);
    frame_done("rot");
    check("rot_op_arg", 32'(op_arg), 32'd10);

    // Bad arguments and error clear
    issue("rot91", 4'd0, 8'd91, 1'b0);
    check("rot91_error", 32'(host_if.error), 32'd1);
    check("rot91_op_kept", 32'(op_arg), 32'd10);
    issue("clr", 4'd4, 8'd0, 1'b0);
    check("clr_error", 32'(host_if.error), 32'd0);
    issue("zoom0", 4'd1, 8'd0, 1'b0);
    check("zoom0_error", 32'(host_if.error), 32'd1);
    issue("clr2", 4'd4, 8'd0, 1'b0);
    check("clr2_error", 32'(host_if.error), 32'd0);
    issue("cmd7", 4'd7, 8'd0, 1'b0);
    check("cmd7_error", 32'(host_if.error), 32'd1);
    check("cmd7_op_sel_kept", 32'(op_sel), 32'd0);
    issue("clr3", 4'd4, 8'd0, 1'b0);

    // ROTATE at the 90 boundary is legal
    issue("rot90", 4'd0, 8'd90, 1'b1);
    check("rot90_op_arg", 32'(op_arg), 32'd90);
    check("rot90_error", 32'(host_if.error), 32'd0);
    frame_done("rot90");

    // Held request: one ack for the whole frame, re-armed by a one-cycle drop
    host_if.cmd       = 4'd1;
    host_if.cmd_data  = 8'd3;
    host_if.cmd_valid = 1'b1;
    tick();
    check("held_ack", 32'(host_if.cmd_ack), 32'd1);
    check("held_op", {24'd0, 6'd0, op_sel}, 32'd1);
    check("held_arg", 32'(op_arg), 32'd3);
    ack_seen = 0;
    strobes(Fp);
    check("held_refresh", 32'(host_if.refresh), 32'd1);
    tick();
    tick();
    if (host_if.cmd_ack) ack_seen++;
    check("held_single_ack", 32'(ack_seen), 32'd0);
    check("held_idle", 32'(host_if.busy), 32'd0);
    host_if.cmd_valid = 1'b0;
    tick();
    host_if.cmd       = 4'd3;
    host_if.cmd_valid = 1'b1;
    tick();
    check("rearm_ack", 32'(host_if.cmd_ack), 32'd1);
    check("rearm_start", 32'(start), 32'd1);
    check("rearm_op_sel", 32'(op_sel), 32'd3);
    host_if.cmd_valid = 1'b0;
    frame_done("rearm");

    // Request sampled at the same edge as the final strobe is taken one edge later
    issue("same", 4'd2, 8'd0, 1'b1);
    strobes(Fp - 1);
    host_if.cmd       = 4'd3;
    host_if.cmd_valid = 1'b1;
    wr_valid          = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("same_refresh", 32'(host_if.refresh), 32'd1);
    check("same_no_ack", 32'(host_if.cmd_ack), 32'd0);
    tick();
    check("same_late_ack", 32'(host_if.cmd_ack), 32'd1);
    check("same_late_start", 32'(start), 32'd1);
    check("same_late_op", 32'(op_sel), 32'd3);
    host_if.cmd_valid = 1'b0;
    frame_done("same_frame");

    // Reset mid-frame
    issue("mid", 4'd0, 8'd45, 1'b1);
    strobes(Fp / 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(host_if.busy), 32'd0);
    check("mid_rst_op", {22'd0, op_sel, op_arg}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_no_refresh", 32'(host_if.refresh), 32'd0);
    issue("post", 4'd1, 8'd2, 1'b1);
    frame_done("post");

`ifdef IMGPROC_CMD_TIMEOUT_EN
    // Watchdog fires after To cycles without a strobe
    issue("wd", 4'd2, 8'd0, 1'b1);
    refresh_seen = 0;
    strobes(10);
    for (int i = 0; i < To - 1; i++) begin
      tick();
      if (host_if.refresh) refresh_seen++;
    end
    check("wd_busy_pre", 32'(host_if.busy), 32'd1);
    tick();
    if (host_if.refresh) refresh_seen++;
    check("wd_busy", 32'(host_if.busy), 32'd0);
    check("wd_error", 32'(host_if.error), 32'd1);
    tick();
    if (host_if.refresh) refresh_seen++;
    check("wd_no_refresh", 32'(refresh_seen), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
